// File: rtl/serial_wb_deser.sv
// Serial-to-parallel result deserializer: assembles LSB-first bit frames into
// WIDTH-bit words and presents them as register-file write-backs.
module serial_wb_deser #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bit_valid,
  input  logic              bit_start,
  input  logic              bit_in,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   shreg;
  logic [ADDR_W-1:0]  frame_addr;

  logic [WIDTH-1:0]   shifted;
  logic               last_bit;
  logic               load_ok;

  always_comb begin
    shifted  = {bit_in, shreg[WIDTH-1:1]};
    last_bit = (state == SHIFT) && bit_valid && !bit_start &&
               (count == CNT_W'(WIDTH - 1));
    load_ok  = !wb_valid || wb_ready;
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      shreg      <= '0;
      frame_addr <= '0;
      wb_valid   <= 1'b0;
      wb_addr    <= '0;
      wb_data    <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      // Consumed word drops wb_valid unless a completing frame reloads it below.
      if (wb_valid && wb_ready)
        wb_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bit_valid) begin
            if (bit_start) begin
              shreg      <= shifted;
              frame_addr <= rd_addr;
              count      <= CNT_W'(1);
              state      <= SHIFT;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        SHIFT: begin
          if (bit_valid) begin
            shreg <= shifted;
            if (bit_start) begin
              frame_err  <= 1'b1;
              frame_addr <= rd_addr;
              count      <= CNT_W'(1);
            end else if (last_bit) begin
              state <= IDLE;
              count <= '0;
              // Writes to register 0 are silently discarded.
              if (frame_addr != '0) begin
                if (load_ok) begin
                  wb_valid <= 1'b1;
                  wb_addr  <= frame_addr;
                  wb_data  <= shifted;
                end else begin
                  overrun <= 1'b1;
                end
              end
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
